// File: rtl/shift_reg.sv
`timescale 1ns/1ps
// shift_reg: 16 independent D-bit history shifters; data_out is data_in delayed by D shifting edges.
// Optional port en (macro SHIFT_REG_ENABLE_EN) gates shifting; with the macro undefined it shifts every edge.
module shift_reg #(
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst,
`ifdef SHIFT_REG_ENABLE_EN
  input  logic         en,
`endif
  input  logic [15:0]  data_in,
  output logic [15:0]  data_out,
  output logic [D-1:0] hr_0,
  output logic [D-1:0] hr_1,
  output logic [D-1:0] hr_2,
  output logic [D-1:0] hr_3,
  output logic [D-1:0] hr_4,
  output logic [D-1:0] hr_5,
  output logic [D-1:0] hr_6,
  output logic [D-1:0] hr_7,
  output logic [D-1:0] hr_8,
  output logic [D-1:0] hr_9,
  output logic [D-1:0] hr_10,
  output logic [D-1:0] hr_11,
  output logic [D-1:0] hr_12,
  output logic [D-1:0] hr_13,
  output logic [D-1:0] hr_14,
  output logic [D-1:0] hr_15
);

  logic         shift;
  logic [D-1:0] hist [16];

`ifdef SHIFT_REG_ENABLE_EN
  assign shift = en;
`else
  assign shift = 1'b1;
`endif

  // Bit 0 takes the newest sample; bit D-1 (the oldest) falls off the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) hist[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < 16; i++) hist[i] <= {hist[i][D-2:0], data_in[i]};
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < 16; i++) data_out[i] = hist[i][D-1];
  end

  assign hr_0  = hist[0];
  assign hr_1  = hist[1];
  assign hr_2  = hist[2];
  assign hr_3  = hist[3];
  assign hr_4  = hist[4];
  assign hr_5  = hist[5];
  assign hr_6  = hist[6];
  assign hr_7  = hist[7];
  assign hr_8  = hist[8];
  assign hr_9  = hist[9];
  assign hr_10 = hist[10];
  assign hr_11 = hist[11];
  assign hr_12 = hist[12];
  assign hr_13 = hist[13];
  assign hr_14 = hist[14];
  assign hr_15 = hist[15];

endmodule

// File: tb/tb_shift_reg.sv
`timescale 1ns/1ps
// Directed bench for shift_reg at D=3: vector table plus reset and enable sequences.
module tb_shift_reg;
  localparam int D = 3;

  logic         clk;
  logic         rst;
  logic [15:0]  data_in;
  logic [15:0]  data_out;
  logic [D-1:0] hr_0, hr_1, hr_2, hr_3, hr_4, hr_5, hr_6, hr_7;
  logic [D-1:0] hr_8, hr_9, hr_10, hr_11, hr_12, hr_13, hr_14, hr_15;
  logic [47:0]  hr_all;
`ifdef SHIFT_REG_ENABLE_EN
  logic         en;
`endif

  int errors = 0;
  int checks = 0;

  shift_reg #(.D(D)) dut (
    .clk(clk), .rst(rst),
`ifdef SHIFT_REG_ENABLE_EN
    .en(en),
`endif
    .data_in(data_in), .data_out(data_out),
    .hr_0(hr_0), .hr_1(hr_1), .hr_2(hr_2), .hr_3(hr_3),
    .hr_4(hr_4), .hr_5(hr_5), .hr_6(hr_6), .hr_7(hr_7),
    .hr_8(hr_8), .hr_9(hr_9), .hr_10(hr_10), .hr_11(hr_11),
    .hr_12(hr_12), .hr_13(hr_13), .hr_14(hr_14), .hr_15(hr_15)
  );

  // Lane i occupies bits [3i+2:3i].
  assign hr_all = {hr_15, hr_14, hr_13, hr_12, hr_11, hr_10, hr_9, hr_8,
                   hr_7, hr_6, hr_5, hr_4, hr_3, hr_2, hr_1, hr_0};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_out;
    logic        chk_hr;
    logic [47:0] exp_hr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic setv(input int k, input logic [15:0] din, input logic [15:0] dout,
                      input logic chk, input logic [47:0] hr);
    vecs[k].din     = din;
    vecs[k].exp_out = dout;
    vecs[k].chk_hr  = chk;
    vecs[k].exp_hr  = hr;
  endtask

  // Drive a sample, take one rising edge, return on the following falling edge.
  task automatic tick(input logic [15:0] d);
    data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1);
  end

  initial begin
    // Hold data 0x0064 for 3 edges, one edge of 0x000A, then 100,10,30,21,110 x2 and a zero flush.
    setv(0,  16'h0064, 16'h0000, 1'b1, 48'h0000_0004_8040);
    setv(1,  16'h0064, 16'h0000, 1'b1, 48'h0000_000D_80C0);
    setv(2,  16'h0064, 16'h0064, 1'b1, 48'h0000_001F_81C0);
    setv(3,  16'h000A, 16'h0064, 1'b1, 48'h0000_001B_0388);
    setv(4,  16'h0064, 16'h0064, 1'b1, 48'h0000_0016_8550);
    setv(5,  16'h0064, 16'h000A, 1'b0, 48'h0);
    setv(6,  16'h000A, 16'h0064, 1'b0, 48'h0);
    setv(7,  16'h000A, 16'h0064, 1'b0, 48'h0);
    setv(8,  16'h001E, 16'h000A, 1'b0, 48'h0);
    setv(9,  16'h001E, 16'h000A, 1'b0, 48'h0);
    setv(10, 16'h0015, 16'h001E, 1'b0, 48'h0);
    setv(11, 16'h0015, 16'h001E, 1'b0, 48'h0);
    setv(12, 16'h006E, 16'h0015, 1'b0, 48'h0);
    setv(13, 16'h006E, 16'h0015, 1'b0, 48'h0);
    setv(14, 16'h0000, 16'h006E, 1'b0, 48'h0);
    setv(15, 16'h0000, 16'h006E, 1'b0, 48'h0);
    setv(16, 16'h0000, 16'h0000, 1'b1, 48'h0);

    rst     = 1'b1;
    data_in = 16'hFFFF;
`ifdef SHIFT_REG_ENABLE_EN
    en      = 1'b1;
`endif
    // Edges during reset must not load anything.
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold hr", hr_all, 48'h0);
    check("reset_hold data_out", data_out, 48'h0);
    rst = 1'b0;
    #1;
    check("reset_release hr", hr_all, 48'h0);
    check("reset_release data_out", data_out, 48'h0);

    for (int k = 0; k < 17; k++) begin
      tick(vecs[k].din);
      check($sformatf("vec%0d data_out", k), data_out, vecs[k].exp_out);
      if (vecs[k].chk_hr) check($sformatf("vec%0d hr", k), hr_all, vecs[k].exp_hr);
    end

    // Fill all lanes with ones, then reset asynchronously mid-cycle.
    tick(16'hFFFF);
    tick(16'hFFFF);
    tick(16'hFFFF);
    check("ones hr", hr_all, 48'hFFFF_FFFF_FFFF);
    check("ones data_out", data_out, 48'hFFFF);
    #5;
    rst = 1'b1;
    #1;
    check("async_rst hr", hr_all, 48'h0);
    check("async_rst data_out", data_out, 48'h0);
    @(negedge clk);
    rst = 1'b0;

    // Restart: older history positions start from zero.
    tick(16'hFFFF);
    check("restart1 hr", hr_all, 48'h2492_4924_9249);
    check("restart1 data_out", data_out, 48'h0);
    tick(16'hFFFF);
    check("restart2 hr", hr_all, 48'h6DB6_DB6D_B6DB);
    check("restart2 data_out", data_out, 48'h0);
    tick(16'hFFFF);
    check("restart3 data_out", data_out, 48'hFFFF);

`ifdef SHIFT_REG_ENABLE_EN
    tick(16'h0000);
    check("en_pre hr", hr_all, 48'hDB6D_B6DB_6DB6);
    en = 1'b0;
    tick(16'h1234);
    check("en_off1 hr", hr_all, 48'hDB6D_B6DB_6DB6);
    tick(16'hABCD);
    check("en_off2 hr", hr_all, 48'hDB6D_B6DB_6DB6);
    tick(16'h5555);
    check("en_off3 hr", hr_all, 48'hDB6D_B6DB_6DB6);
    tick(16'h0F0F);
    check("en_off4 hr", hr_all, 48'hDB6D_B6DB_6DB6);
    check("en_off4 data_out", data_out, 48'hFFFF);
    en = 1'b1;
    tick(16'h0000);
    check("en_on1 hr", hr_all, 48'h9249_2492_4924);
    check("en_on1 data_out", data_out, 48'hFFFF);
    tick(16'h0000);
    check("en_on2 data_out", data_out, 48'h0);
    tick(16'hFFFF);
    en = 1'b0;
    #5;
    rst = 1'b1;
    #1;
    check("en_off_rst hr", hr_all, 48'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg.md
SHIFT_REG -- requirements
Module: shift_reg

Interface
REQ-001 The block SHALL expose parameter D, default 3, giving the history depth in clock cycles per input bit; legal range 2..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port data_in, input, 16 bits: the sample word shifted in every cycle.
REQ-005 Port data_out, output, 16 bits: data_in delayed by D cycles.
REQ-006 Ports hr_0 .. hr_15, output, D bits each: hr_i is the D-cycle history of data_in bit i.
REQ-007 Port en, input, 1 bit: shift enable; present only when SHIFT_REG_ENABLE_EN is defined (see Configuration).

Function
REQ-008 Each hr_i SHALL be a D-bit shift register: on every shifting rising edge, hr_i <= {hr_i[D-2:0], data_in[i]}.
REQ-009 hr_i[0] SHALL hold the most recent sample of data_in[i]; hr_i[D-1] SHALL hold the oldest.
REQ-010 data_out[i] SHALL equal hr_i[D-1] combinationally, so data_out is data_in from exactly D shifting edges earlier.
REQ-011 Latency: a value applied to data_in before edge N SHALL appear in hr_i[0] after edge N and on data_out after edge N+D-1.
REQ-012 All 16 lanes SHALL shift simultaneously and independently; no bit SHALL move between lanes.
REQ-013 Outputs hr_0..hr_15 SHALL be registered (direct flop outputs), with no combinational path from data_in.
REQ-014 A data_in value held constant for at least D shifting edges SHALL make each hr_i all-ones or all-zeros matching bit i, and data_out equal to that value.
REQ-015 There is no handshake, no overflow and no wrap-around; the oldest bit SHALL be discarded on each shift.

Reset
REQ-016 While rst is 1, all hr_i SHALL be 0 and data_out SHALL be 0x0000, regardless of clk.
REQ-017 Reset assertion SHALL take effect immediately (asynchronously), including mid-stream; history is lost.
REQ-018 On the first rising edge after rst deasserts, normal shifting SHALL resume, with zeros in the older history positions.

Configuration
REQ-019 Macro SHIFT_REG_ENABLE_EN: when defined, port en SHALL exist, shifting SHALL occur only on edges where en=1, and with en=0 all registers SHALL hold; reset SHALL override en.
REQ-020 When SHIFT_REG_ENABLE_EN is not defined, port en SHALL be absent and shifting SHALL occur on every rising edge.

Verification (D=3, 20 ns clock, macro undefined unless stated)
REQ-021 Assert rst with any data_in, then release -> all hr_i = 3'b000 and data_out = 0x0000 until the first edge.
REQ-022 Hold data_in = 100 (0x0064) for 3 edges -> hr_2, hr_5 and hr_6 = 3'b111, all other hr_i = 3'b000, data_out = 100.
REQ-023 Then drive data_in = 10 (0x000A) for 1 edge -> hr_1 = hr_3 = 3'b001, hr_2 = hr_5 = hr_6 = 3'b110, and data_out still 100.
REQ-024 Drive data_in = 100, 10, 30, 21, 110, each for 2 edges -> data_out reproduces the same sequence delayed by exactly 3 edges.
REQ-025 Assert rst between clock edges while hr_2 = 3'b111 -> all outputs read 0 before the next edge.
REQ-026 With SHIFT_REG_ENABLE_EN defined and en = 0 for 4 edges while data_in changes -> all outputs unchanged; with en = 1, shifting resumes on the next edge.
